display_scan_mux: RTL and testbench

Parametrised time-multiplexed display scanner for common-anode 7-segment banks. It holds an N-digit value in a frame-synchronised double buffer and rotates one active-low anode per refresh slot. It presents the selected digit's code on `y` for the downstream 7-segment decoder. It replaces the fixed 4-digit select-driven mux: the refresh counter and anode rotation are internal, and digit count, code width and dwell are parameters.

---
 rtl/display_scan_mux.sv | 75 +++++++
 tb/tb_display_scan_mux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: N-digit time-multiplexed common-anode scanner with a frame-synchronised double buffer.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module display_scan_mux #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 4,
  parameter int DIV    = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load,
  input  logic [DIGITS*DATA_W-1:0] data_in,
  output logic [DIGITS-1:0]        anode,
  output logic [DATA_W-1:0]        y,
  output logic                     blank,
  output logic                     frame_start
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  logic [PW-1:0] pre;
  logic [IW-1:0] idx, nidx;
  logic [DIGITS*DATA_W-1:0] shadow, active, src;
  logic pending, tick, bnd, hide;
  // At a frame boundary with a pending update, digit 0 is fetched straight from shadow
  always_comb begin
    tick = enable && pre == PMAX;
    nidx = idx == IMAX ? '0 : idx + 1'b1;
    bnd  = tick && nidx == '0;
    src  = bnd && pending ? shadow : active;
  end
`ifdef DISP_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign lz[i] = ~|src[DIGITS*DATA_W-1:i*DATA_W];
  end
  assign hide = nidx != '0 && lz[nidx];
`else
  assign hide = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      pre         <= '0;
      idx         <= IMAX;
      anode       <= '1;
      y           <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
    end else begin
      if (enable) pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx   <= nidx;
        anode <= hide ? '1 : ~(DIGITS'(1) << nidx);
        y     <= src[nidx*DATA_W +: DATA_W];
        blank <= hide;
      end else if (!enable) begin
        anode <= '1;
        blank <= 1'b1;
      end
      frame_start <= bnd;
      if (bnd && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed scenarios plus randomized run against a time-based reference model.
module tb_display_scan_mux;
  localparam int DIGITS = 4;
  localparam int DATA_W = 4;
  localparam int DIV    = 3;
  logic clk = 0, reset = 1, enable = 1, load = 0;
  logic [15:0] data_in = '0;
  logic [3:0] anode, y;
  logic blank, frame_start;
  int checks = 0, failures = 0;
  int ecnt;
  logic [15:0] sh, act;
  logic pend;
  logic [3:0] m_anode, m_y;
  logic m_blank, m_fs;
  logic [3:0] got [0:15];

  display_scan_mux #(.DIGITS(DIGITS), .DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
    .anode(anode), .y(y), .blank(blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Model counts enabled cycles; every DIV-th enabled cycle starts the next slot in rotation.
  task automatic cycle();
    int i;
    bit tk;
    logic [15:0] s;
    @(posedge clk);
    if (reset) begin
      ecnt = 0; sh = '0; act = '0; pend = 0;
      m_anode = 4'hF; m_y = 4'h0; m_blank = 1; m_fs = 0;
    end else begin
      m_fs = 0;
      tk = 0;
      if (enable) begin
        ecnt++;
        tk = (ecnt % DIV) == 0;
      end
      if (tk) begin
        i = (ecnt / DIV - 1) % DIGITS;
        s = (i == 0 && pend) ? sh : act;
        m_y = 4'(s >> (4 * i));
        m_anode = ~(4'b0001 << i);
        m_blank = 0;
        m_fs = (i == 0);
`ifdef DISP_LZ_BLANK_EN
        if (i > 0 && (s >> (4 * i)) == 0) begin
          m_anode = 4'hF;
          m_blank = 1;
        end
`endif
        if (i == 0 && pend) begin
          act = sh;
          pend = 0;
        end
      end else if (!enable) begin
        m_anode = 4'hF;
        m_blank = 1;
      end
      if (load) begin
        sh = data_in;
        pend = 1;
      end
    end
    #1;
  endtask

  task automatic wait_enter(input logic [3:0] t, output bit ok);
    logic [3:0] p;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      p = anode;
      cycle();
      if (anode == t && p != t) ok = 1;
    end
  endtask

  task automatic collect(input int n, output bit ok);
    logic [3:0] p;
    int k;
    k = 0;
    for (int c = 0; c < n * DIV + 10 && k < n; c++) begin
      p = anode;
      cycle();
      if (anode != p) begin
        got[k] = y;
        k++;
      end
    end
    ok = (k == n);
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; load = 0; data_in = '0;
    cycle(); cycle();
    checks++;
    if (anode !== 4'hF || y !== 4'h0 || blank !== 1'b1 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_state anode=%b y=%h blank=%b fs=%b required 1111 0 1 0", anode, y, blank, frame_start);
    end
    reset = 0; load = 1; data_in = 16'h4321;
    cycle();
    load = 0;
    checks++;
    if (anode !== 4'hF) begin failures++; $display("FAIL reset_edge1 anode=%b required 1111", anode); end
    cycle();
    checks++;
    if (anode !== 4'hF) begin failures++; $display("FAIL reset_edge2 anode=%b required 1111", anode); end
    cycle();
    checks++;
    if (anode !== 4'b1110 || y !== 4'h1 || blank !== 1'b0 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_tick anode=%b y=%h blank=%b fs=%b required 1110 1 0 1", anode, y, blank, frame_start);
    end
  endtask

  task automatic test_scan_order();
    int d, fs_cnt;
    logic [3:0] ea;
    fs_cnt = 0;
    for (int k = 1; k < 24; k++) begin
      cycle();
      d = (k / DIV) % DIGITS;
      ea = ~(4'b0001 << d);
      checks++;
      if (anode !== ea || y !== 4'(d + 1) || frame_start !== (k % 12 == 0)) begin
        failures++;
        $display("FAIL scan_order k=%0d anode=%b y=%h fs=%b required %b %h %b", k, anode, y, frame_start, ea, 4'(d + 1), k % 12 == 0);
      end
      if (frame_start) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 1) begin failures++; $display("FAIL frame_pulse_count got=%0d required 1", fs_cnt); end
  endtask

  task automatic test_tear_free();
    bit ok;
    logic [3:0] exp6 [0:5];
    exp6 = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    wait_enter(4'b1101, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tear_wait digit1 never lit anode=%b", anode); end
    load = 1; data_in = 16'h8765;
    cycle();
    load = 0;
    collect(6, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL tear_collect timeout"); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got[k] !== exp6[k]) begin failures++; $display("FAIL tear_free slot%0d y=%h required %h", k, got[k], exp6[k]); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [15:0] a, b;
    logic [31:0] seq;
    a = 16'($urandom);
    b = 16'($urandom);
    wait_enter(4'b0111, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_wait digit3 never lit anode=%b", anode); end
    load = 1; data_in = a;
    cycle();
    load = 0;
    cycle();
    load = 1; data_in = b;
    cycle();
    load = 0;
    checks++;
    if (anode !== 4'b1110 || y !== a[3:0] || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL simul_boundary anode=%b y=%h fs=%b required 1110 %h 1", anode, y, frame_start, a[3:0]);
    end
    collect(7, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_collect timeout"); end
    seq = {b, a};
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[k] !== 4'(seq >> (4 * (k + 1)))) begin
        failures++;
        $display("FAIL simultaneous slot%0d y=%h required %h", k, got[k], 4'(seq >> (4 * (k + 1))));
      end
    end
  endtask

  task automatic test_disable();
    bit ok;
    logic [3:0] yh;
    logic [15:0] cur;
    cur = act;
    wait_enter(4'b1011, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dis_wait digit2 never lit anode=%b", anode); end
    cycle();
    yh = y;
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (anode !== 4'hF || blank !== 1'b1 || y !== yh) begin
        failures++;
        $display("FAIL disabled k=%0d anode=%b blank=%b y=%h required 1111 1 %h", k, anode, blank, y, yh);
      end
    end
    enable = 1;
    cycle();
    checks++;
    if (anode !== 4'hF) begin failures++; $display("FAIL reenable_dwell anode=%b required 1111", anode); end
    cycle();
    checks++;
    if (anode !== 4'b0111 || y !== cur[15:12] || blank !== 1'b0) begin
      failures++;
      $display("FAIL reenable_digit3 anode=%b y=%h blank=%b required 0111 %h 0", anode, y, blank, cur[15:12]);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int n = 0; n < 3000; n++) begin
      reset  = $urandom_range(0, 299) == 0;
      enable = $urandom_range(0, 9) != 0;
      load   = $urandom_range(0, 19) == 0;
      for (int j = 0; j < 4; j++) d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      data_in = d;
      cycle();
      checks++;
      if (anode !== m_anode || y !== m_y || blank !== m_blank || frame_start !== m_fs) begin
        failures++;
        $display("FAIL random n=%0d anode=%b y=%h blank=%b fs=%b required %b %h %b %b",
                 n, anode, y, blank, frame_start, m_anode, m_y, m_blank, m_fs);
      end
    end
    reset = 0; enable = 1; load = 0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_simultaneous();
    test_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
